// File: rtl/cpu_timing_sequencer_pkg.sv
// Purpose: shared encodings and defaults for the CPU timing sequencer slice.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
// Contents: cpu_state encoding, timing-state count default, CPU data width,
//           and the active-state helper used by the sequencer.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_FAULT  = 2'b11
  } cpu_state_e;

  localparam int NUM_T_DEFAULT    = 7;
  localparam int CPU_DATA_W       = 19;
  localparam int WAIT_MAX_DEFAULT = 15;
  localparam int ICNT_W_DEFAULT   = 16;

  // The control unit may only commit while the sequencer is executing.
  function automatic logic is_active(input cpu_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_timing_sequencer_if.sv
// Purpose: control-unit <-> timing-sequencer signal bundle.
// Latency: n/a (wires only).
// Backpressure: memory stalls travel as mem_rd/mem_wr pending without mem_ack.
// Ports: master = control unit / memory side (drives requests, sees T-state);
//        slave  = timing sequencer (sees requests, drives T, ctrl_en, status).
interface cpu_timing_sequencer_if #(
  parameter int NUM_T  = 7,
  parameter int ICNT_W = 16
);
  localparam int SC_W = $clog2(NUM_T);

  logic              sc_clr;
  logic              mem_rd;
  logic              mem_wr;
  logic              mem_ack;
  logic              run_req;
  logic              halt_req;
  logic              step_req;
  logic              err_clr;

  logic [NUM_T-1:0]  T;
  logic [SC_W-1:0]   sc_value;
  logic              ctrl_en;
  logic [1:0]        cpu_state;
  logic              mem_timeout;
  logic              seq_overrun;
  logic [ICNT_W-1:0] instr_count;

  modport master (
    output sc_clr, mem_rd, mem_wr, mem_ack, run_req, halt_req, step_req, err_clr,
    input  T, sc_value, ctrl_en, cpu_state, mem_timeout, seq_overrun, instr_count
  );

  modport slave (
    input  sc_clr, mem_rd, mem_wr, mem_ack, run_req, halt_req, step_req, err_clr,
    output T, sc_value, ctrl_en, cpu_state, mem_timeout, seq_overrun, instr_count
  );

endinterface

// File: rtl/cpu_timing_sequencer_wait_timer.sv
// Purpose: counts stalled memory cycles and flags a timeout at WAIT_MAX.
// Latency: counter updates on the next edge; timeout is combinational.
// Backpressure: none; it only observes the stall condition.
// Ports: clk/rst; active, mem_pend, mem_ack, ctrl_en in; timeout out.
module cpu_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_pend,
  input  logic mem_ack,
  input  logic ctrl_en,
  output logic timeout
);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stalled;

  assign stalled = active && mem_pend && !mem_ack;
  assign timeout = stalled && (cnt_q == CNT_W'(WAIT_MAX));

  // Clearing on timeout keeps the counter in range even at WAIT_MAX=2^n-1;
  // the sequencer leaves the active states on that edge anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (!active || ctrl_en || timeout) begin
      cnt_d = '0;
    end else if (stalled) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_timing_sequencer.sv
// Purpose: one-hot T0..T(NUM_T-1) timing generator with run/halt/step control.
// Latency: ctrl_en is combinational; T, cpu_state and flags update next edge.
// Backpressure: a pending memory access without mem_ack holds the T-state.
// Ports: clk, rst (sync, active-high); bus = slave side of
//        cpu_timing_sequencer_if (requests in; T, sc_value, ctrl_en,
//        cpu_state, mem_timeout, seq_overrun, instr_count out).
module cpu_timing_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_T    = NUM_T_DEFAULT,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT,
  parameter int ICNT_W   = ICNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  cpu_timing_sequencer_if.slave  bus
);
  localparam int              SC_W    = $clog2(NUM_T);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(NUM_T - 1);

  cpu_state_e        state_q, state_d;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic              to_q, to_d;
  logic              ov_q, ov_d;
  logic [ICNT_W-1:0] icnt_q, icnt_d;

  logic active;
  logic mem_pend;
  logic ctrl_en;
  logic timeout;
  logic boundary;

  assign active   = is_active(state_q);
  assign mem_pend = bus.mem_rd || bus.mem_wr;
  // The ack cycle itself completes the access. Reset suppresses the commit
  // so an abandoned instruction never leaves a half-applied strobe behind.
  assign ctrl_en  = active && (!mem_pend || bus.mem_ack) && !rst;
  assign boundary = bus.sc_clr || (sc_q == SC_LAST);

  cpu_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .active   (active),
    .mem_pend (mem_pend),
    .mem_ack  (bus.mem_ack),
    .ctrl_en  (ctrl_en),
    .timeout  (timeout)
  );

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    to_d    = to_q;
    ov_d    = ov_q;
    icnt_d  = icnt_q;

    if (state_q == ST_FAULT) begin
      // Only err_clr leaves FAULT; T stays frozen until then for debug.
      if (bus.err_clr) begin
        state_d = ST_HALTED;
        sc_d    = '0;
        to_d    = 1'b0;
        ov_d    = 1'b0;
      end
    end else if (timeout) begin
      state_d = ST_FAULT;
      to_d    = 1'b1;
    end else if (ctrl_en) begin
      if (bus.sc_clr) begin
        sc_d   = '0;
        icnt_d = icnt_q + 1'b1;
      end else if (sc_q == SC_LAST) begin
        // Ran off the end of the sequence: wrap, but do not count it retired.
        sc_d = '0;
        ov_d = 1'b1;
      end else begin
        sc_d = sc_q + 1'b1;
      end
      // ctrl_en implies RUN or STEP, so halt_req only matters in RUN here.
      if (boundary && ((state_q == ST_STEP) || bus.halt_req)) begin
        state_d = ST_HALTED;
      end
    end else if ((state_q == ST_HALTED) && !bus.halt_req) begin
      if (bus.step_req) begin
        state_d = ST_STEP;
      end else if (bus.run_req) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HALTED;
      sc_q    <= '0;
      to_q    <= 1'b0;
      ov_q    <= 1'b0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      to_q    <= to_d;
      ov_q    <= ov_d;
      icnt_q  <= icnt_d;
    end
  end

  // Decoding T from the binary counter keeps it one-hot by construction.
  assign bus.T           = {{(NUM_T-1){1'b0}}, 1'b1} << sc_q;
  assign bus.sc_value    = sc_q;
  assign bus.ctrl_en     = ctrl_en;
  assign bus.cpu_state   = state_q;
  assign bus.mem_timeout = to_q;
  assign bus.seq_overrun = ov_q;
  assign bus.instr_count = icnt_q;

endmodule

// File: tb/tb_cpu_timing_sequencer.sv
// Purpose: self-checking bench for cpu_timing_sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_cpu_timing_sequencer;
  localparam int NUM_T    = 7;
  localparam int WAIT_MAX = 15;
  localparam int ICNT_W   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_timing_sequencer_if #(.NUM_T(NUM_T), .ICNT_W(ICNT_W)) bus ();

  cpu_timing_sequencer #(
    .NUM_T    (NUM_T),
    .WAIT_MAX (WAIT_MAX),
    .ICNT_W   (ICNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 halted, 1 run, 2 step, 3 fault.
  int m_state, m_t, m_wait, m_to, m_ov, m_icnt;
  logic [3:0] obs_ctrl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_t = 0; m_wait = 0; m_to = 0; m_ov = 0; m_icnt = 0;
  endtask

  task automatic drive(input bit r, input bit sc, input bit rd, input bit wr,
                       input bit ack, input bit run, input bit halt,
                       input bit step, input bit eclr);
    bit act, ctrl;
    @(negedge clk);
    rst = r;
    bus.sc_clr = sc; bus.mem_rd = rd; bus.mem_wr = wr; bus.mem_ack = ack;
    bus.run_req = run; bus.halt_req = halt; bus.step_req = step; bus.err_clr = eclr;
    #1;
    act  = (m_state == 1) || (m_state == 2);
    ctrl = !r && act && (!(rd || wr) || ack);
    obs_ctrl = {obs_ctrl[2:0], bus.ctrl_en};
    check("T",           32'(bus.T),           32'(1) << m_t);
    check("sc_value",    32'(bus.sc_value),    32'(m_t));
    check("ctrl_en",     32'(bus.ctrl_en),     32'(ctrl));
    check("cpu_state",   32'(bus.cpu_state),   32'(m_state));
    check("mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
    check("seq_overrun", 32'(bus.seq_overrun), 32'(m_ov));
    check("instr_count", 32'(bus.instr_count), 32'(m_icnt % (1 << ICNT_W)));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (m_state == 3) begin
      if (eclr) begin
        m_state = 0; m_t = 0; m_to = 0; m_ov = 0;
      end
    end else if (act) begin
      if (ctrl) begin
        m_wait = 0;
        if (sc) begin
          m_t = 0; m_icnt++;
        end else if (m_t == NUM_T - 1) begin
          m_t = 0; m_ov = 1;
        end else begin
          m_t++;
        end
        if ((sc || m_t == 0) && (m_state == 2 || halt)) m_state = 0;
      end else if (m_wait == WAIT_MAX) begin
        m_state = 3; m_to = 1; m_wait = 0;
      end else begin
        m_wait++;
      end
    end else if (!halt) begin
      if (step) m_state = 2;
      else if (run) m_state = 1;
    end
  endtask

  bit stall;

  initial begin
    bus.sc_clr = 0; bus.mem_rd = 0; bus.mem_wr = 0; bus.mem_ack = 0;
    bus.run_req = 0; bus.halt_req = 0; bus.step_req = 0; bus.err_clr = 0;
    obs_ctrl = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    #2;
    check("rst_T",    32'(bus.T), 32'h1);
    check("rst_sc",   32'(bus.sc_value), 0);
    check("rst_ctrl", 32'(bus.ctrl_en), 0);
    check("rst_st",   32'(bus.cpu_state), 0);
    check("rst_icnt", 32'(bus.instr_count), 0);
    check("rst_flags", 32'({bus.mem_timeout, bus.seq_overrun}), 0);

    // Free run, sc_clr in T3.
    drive(0,0,0,0,0,1,0,0,0);
    drive(0,0,0,0,0,1,0,0,0);
    drive(0,0,0,0,0,1,0,0,0);
    drive(0,0,0,0,0,1,0,0,0);
    drive(0,1,0,0,0,1,0,0,0);
    check("s1_ctrl", 32'(obs_ctrl), 32'hF);
    #2;
    check("s1_icnt", 32'(bus.instr_count), 1);
    check("s1_sc",   32'(bus.sc_value), 0);

    // Memory read in T1 acked after three wait cycles.
    drive(0,0,0,0,0,0,0,0,0);
    repeat (3) drive(0,0,1,0,0,0,0,0,0);
    drive(0,0,1,0,1,0,0,0,0);
    check("s2_ctrl", 32'(obs_ctrl), 32'h1);
    #2;
    check("s2_sc", 32'(bus.sc_value), 2);

    // Read in T1 never acked: fault on the 17th cycle, then err_clr.
    drive(0,1,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0,0);
    repeat (16) drive(0,0,1,0,0,0,0,0,0);
    #2;
    check("s3_st", 32'(bus.cpu_state), 3);
    check("s3_to", 32'(bus.mem_timeout), 1);
    check("s3_sc", 32'(bus.sc_value), 1);
    drive(0,1,1,0,1,1,0,1,0);
    drive(0,0,0,0,0,0,0,0,1);
    #2;
    check("s3_clr_st", 32'(bus.cpu_state), 0);
    check("s3_clr_T",  32'(bus.T), 32'h1);
    check("s3_clr_to", 32'(bus.mem_timeout), 0);

    // Halt requested in T2, instruction ends in T4; then a single step.
    drive(0,0,0,0,0,1,0,0,0);
    drive(0,0,0,0,0,1,0,0,0);
    drive(0,0,0,0,0,1,0,0,0);
    drive(0,0,0,0,0,1,1,0,0);
    drive(0,0,0,0,0,1,1,0,0);
    drive(0,1,0,0,0,1,1,0,0);
    #2;
    check("s4_st",   32'(bus.cpu_state), 0);
    check("s4_icnt", 32'(bus.instr_count), 3);
    drive(0,0,0,0,0,1,1,1,0);
    drive(0,0,0,0,0,0,0,1,0);
    drive(0,0,0,0,0,0,0,0,0);
    drive(0,0,0,0,0,0,0,0,0);
    drive(0,1,0,0,0,0,0,0,0);
    #2;
    check("s4_step_st",   32'(bus.cpu_state), 0);
    check("s4_step_icnt", 32'(bus.instr_count), 4);

    // No sc_clr: T6 commits and wraps with overrun.
    drive(0,0,0,0,0,1,0,0,0);
    repeat (NUM_T) drive(0,0,0,0,0,1,0,0,0);
    #2;
    check("s5_ov",   32'(bus.seq_overrun), 1);
    check("s5_icnt", 32'(bus.instr_count), 4);
    check("s5_sc",   32'(bus.sc_value), 0);

    // Reset while a write in T3 is pending.
    repeat (3) drive(0,0,0,0,0,1,0,0,0);
    drive(0,0,0,1,0,1,0,0,0);
    drive(1,0,0,1,0,1,0,0,0);
    check("s6_ctrl", 32'(obs_ctrl[0]), 0);
    #2;
    check("s6_st",   32'(bus.cpu_state), 0);
    check("s6_T",    32'(bus.T), 32'h1);
    check("s6_icnt", 32'(bus.instr_count), 0);
    check("s6_ov",   32'(bus.seq_overrun), 0);

    // Randomized traffic with occasional long memory stalls.
    stall = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, sc, rd, wr, ack, run, halt, step, eclr;
      if (i % 64 == 0) stall = ($urandom_range(0, 3) == 0);
      r    = ($urandom_range(0, 299) == 0);
      sc   = ($urandom_range(0, 4) == 0);
      rd   = stall ? 1'b1 : ($urandom_range(0, 3) == 0);
      wr   = !stall && ($urandom_range(0, 5) == 0);
      ack  = !stall && ($urandom_range(0, 2) == 0);
      run  = ($urandom_range(0, 2) != 0);
      halt = ($urandom_range(0, 19) == 0);
      step = ($urandom_range(0, 7) == 0);
      eclr = ($urandom_range(0, 5) == 0);
      drive(r, sc, rd, wr, ack, run, halt, step, eclr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_timing_sequencer.md
Name: cpu_timing_sequencer

Overview:
- Generates the one-hot timing states T0..T6 that drive the 19-bit CPU control unit.
- Sequences execution: free-run, halt at instruction boundary, and single-step.
- Stretches the current T-state while a memory access waits for acknowledge.
- Produces a commit qualifier (ctrl_en) that gates every control-unit load/inc/dec/stack/write strobe, and traps sequence overrun and memory timeout faults.

Parameters:
- NUM_T, 7, number of timing states (T0..T6); the state counter is $clog2(NUM_T) bits wide.
- WAIT_MAX, 15, cycles a pending memory access may wait for mem_ack before a fault; range 1..255.
- ICNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sc_clr  in  1  sequence-counter clear from the control unit (end of instruction).
- mem_rd  in  1  memory read requested in the current T-state.
- mem_wr  in  1  memory write requested in the current T-state.
- mem_ack  in  1  memory completes the access this cycle.
- run_req  in  1  level; HALTED -> RUN.
- halt_req  in  1  level; RUN -> HALTED at the next instruction boundary.
- step_req  in  1  pulse; execute exactly one instruction from HALTED.
- err_clr  in  1  pulse; FAULT -> HALTED and clears the sticky flags.
- T  out  NUM_T  one-hot timing state; T[0]=T0.
- sc_value  out  3  binary index of the active T-state.
- ctrl_en  out  1  control-unit outputs commit this cycle.
- cpu_state  out  2  00 HALTED, 01 RUN, 10 STEP, 11 FAULT.
- mem_timeout  out  1  sticky; a memory wait exceeded WAIT_MAX.
- seq_overrun  out  1  sticky; T6 was committed without sc_clr.
- instr_count  out  ICNT_W  retired instructions; wraps modulo 2^ICNT_W.

Behaviour:
- Reset (rst=1 at the clock edge):
  - cpu_state=HALTED, T=0000001, sc_value=0, ctrl_en=0.
  - wait counter=0, mem_timeout=0, seq_overrun=0, instr_count=0.
  - Reset mid-access or mid-instruction abandons the access; no commit occurs in the reset cycle.
- Derived signals:
  - active = (cpu_state==RUN || cpu_state==STEP).
  - mem_pend = mem_rd || mem_wr.
- ctrl_en = active && (!mem_pend || mem_ack). This is combinational, with the same-cycle ack counted as completion.
- Advance, evaluated only when ctrl_en=1:
  - If sc_clr: T <= T0, instr_count += 1 (boundary).
  - Else if T6: T <= T0, seq_overrun <= 1, instr_count unchanged (boundary).
  - Else: T shifts to the next state.
- When ctrl_en=0, T holds.
- Memory wait:
  - The wait counter increments each cycle where active && mem_pend && !mem_ack.
  - It clears on any ctrl_en=1 cycle or when not active.
  - If the counter equals WAIT_MAX and mem_ack=0: enter FAULT next cycle and set mem_timeout. T holds its value for debug visibility.
- State transitions (priority top to bottom):
  - FAULT: err_clr -> HALTED, T <= T0, sticky flags cleared. All other inputs are ignored. ctrl_en=0.
  - Any active state with a timeout -> FAULT.
  - RUN at a boundary with halt_req=1 -> HALTED; the instruction commits fully.
  - STEP at a boundary -> HALTED.
  - HALTED: halt_req=1 keeps it HALTED, even with run_req. Otherwise step_req -> STEP, and run_req -> RUN (step has priority over run). T stays T0, ctrl_en=0.
  - step_req in RUN or STEP is ignored. run_req in STEP is ignored until the return to HALTED.
- A memory access spanning N wait cycles plus the ack cycle holds the T-state for N+1 cycles. Exactly one commit occurs, on the ack cycle.
- T is always exactly one-hot. sc_value always equals the index of the set bit.

Decomposition:
- Shared package cpu_pkg holds:
  - cpu_state encoding constants (ST_HALTED, ST_RUN, ST_STEP, ST_FAULT).
  - NUM_T_DEFAULT=7.
  - CPU data width 19.
- One sub-module, cpu_wait_timer: the wait counter plus the timeout compare, parameterised by WAIT_MAX.

Test Plan:
- Reset, run_req=1, no mem, sc_clr asserted in T3 -> T sequence T0,T1,T2,T3,T0; ctrl_en=1 each cycle; instr_count=1.
- In T1 with mem_rd=1, mem_ack after 3 cycles -> T1 held for 4 cycles; ctrl_en=0,0,0,1; then T2.
- mem_rd=1 with mem_ack never (WAIT_MAX=15) -> cpu_state=FAULT on the 17th cycle of T1; mem_timeout=1. err_clr -> HALTED, T=T0, flag cleared.
- RUN, halt_req raised in T2, sc_clr in T4 -> T4 commits; then HALTED, T=T0, ctrl_en=0. step_req pulse -> one instruction runs, back to HALTED; instr_count +1.
- RUN, sc_clr never asserted -> T6 commits, next cycle T0; seq_overrun=1; instr_count unchanged.
- rst asserted in T3 while mem_wr pending -> next cycle HALTED, T=T0, counters 0; no ctrl_en pulse.
